nf_register_pipe: RTL and testbench
===================================

// Module: nf_register_pipe
// PURPOSE
//  Parametrised elastic register pipeline: DEPTH register stages, each holding WIDTH data bits plus a valid flag.
//  Ready/valid handshake on both sides; bubbles collapse; one beat per cycle when the downstream side keeps ready high.
//  Supports a programmable reset value and a synchronous flush.
//  Sits between producers and consumers in the core and peripheral datapaths, wherever registered staging with back-pressure is needed.
// PARAMETERS
//  WIDTH    8     data width in bits; must be >= 1
//  DEPTH    2     number of register stages; must be >= 1
//  RST_VAL  '0    value loaded into every data stage on reset and on flush
// PORTS
//  clk        in   1                    clock; all state updates on the rising edge
//  reset      in   1                    asynchronous, active-high reset
//  flush      in   1                    synchronous clear of all stages
//  in_valid   in   1                    upstream beat valid
//  in_ready   out  1                    pipeline accepts a beat this cycle
//  in_data    in   WIDTH                upstream data
//  out_valid  out  1                    last stage holds a valid beat
//  out_ready  in   1                    downstream accepts a beat
//  out_data   out  WIDTH                data of the last stage
//  occ        out  $clog2(DEPTH+1)      number of valid stages (see CONFIGURATION)
// BEHAVIOUR
//  - State per stage i (0 = input side): vld[i], dat[i].
//  - Reset (asynchronous, active-high):
//      - every vld = 0; every dat = RST_VAL
//      - outputs: out_valid = 0, out_data = RST_VAL, occ = 0
//      - in_ready follows the ready chain below, so it is 1 while reset is asserted and flush is low.
//  - Stage-ready chain (combinational):
//      - rdy[DEPTH-1] = !vld[DEPTH-1] | out_ready
//      - rdy[i] = !vld[i] | rdy[i+1]
//      - in_ready = rdy[0] & !flush
//  - Clock edge, flush = 0, for each stage i where rdy[i] = 1:
//      - vld[i] <= upstream valid (in_valid for i = 0, otherwise vld[i-1])
//      - dat[i] <= upstream data, but only when upstream valid = 1
//      - Data registers never load on a bubble.
//  - Clock edge, flush = 1:
//      - all vld <= 0; all dat <= RST_VAL
//      - A concurrent input beat is not accepted (in_ready = 0).
//      - A concurrent output handshake (out_valid & out_ready) still counts as delivered.
//  - Outputs: out_valid = vld[DEPTH-1]; out_data = dat[DEPTH-1], driven regardless of out_valid.
//  - Latency: an accepted beat into an empty pipe appears on out_valid exactly DEPTH cycles later.
//  - Throughput: 1 beat/cycle while out_ready = 1; no combinational path from in_data to out_data.
//  - Back-pressure: with out_ready = 0, beats fill the stages; after DEPTH accepted beats in_ready = 0.
//  - Full pipe and out_ready = 1 on the same cycle: in_ready = 1; accept and drain happen together.
//  - Ordering: beats leave in acceptance order; no beat is lost or duplicated except by flush or reset.
//  - Reset mid-transfer: all beats are discarded immediately (asynchronous).
//  - in_data is ignored while in_valid = 0.
// CONFIGURATION
//  Macro NF_REGISTER_PIPE_OCC_EN:
//  - Defined:
//      - occ = count of set vld bits, as a registered counter
//      - the counter updates +1 on accept, -1 on delivery, +0 on both, and clears to 0 on flush or reset
//      - range 0..DEPTH, never wraps
//  - Undefined: no counter logic; occ is tied to 0.
// TESTING
//  1 DEPTH=2, WIDTH=8: hold out_ready=1; send 0x11,0x22,0x33 on consecutive cycles -> out 0x11,0x22,0x33 on cycles 2,3,4; in_ready stays 1.
//  2 out_ready=0; send 0xA0,0xA1 -> in_ready=0 after the 2nd accept; occ=2 (macro on); raise out_ready -> 0xA0 then 0xA1.
//  3 Pipe full, out_ready=1 and in_valid=1 (0x55) on the same cycle -> 0xA0 delivered, 0x55 accepted, occ stays 2.
//  4 Two beats held, flush=1 with in_valid=1 (0x77) -> next cycle out_valid=0, out_data=RST_VAL, occ=0; 0x77 not accepted.
//  5 RST_VAL=0x5A; assert reset mid-stream asynchronously -> out_valid=0 and out_data=0x5A before the next edge; occ=0.
//  6 DEPTH=1; random in_valid/out_ready for 10k cycles -> scoreboard: in-order, no loss, no duplicates; occ matches vld count.

Source files
------------

// File: rtl/nf_register_pipe.sv
// Elastic register pipeline: DEPTH ready/valid stages with collapsing bubbles, RST_VAL data reset and sync flush.
// Optional occupancy counter enabled by defining NF_REGISTER_PIPE_OCC_EN; otherwise occ_o is tied to 0.
module nf_register_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] dat_q  [DEPTH];
  logic [WIDTH-1:0] dat_d  [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];

  // Each stage's upstream source: the input port for stage 0, else the previous stage.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_up
      if (gi == 0) begin : g_first
        assign up_vld[gi] = in_valid_i;
        assign up_dat[gi] = in_data_i;
      end else begin : g_rest
        assign up_vld[gi] = vld_q[gi-1];
        assign up_dat[gi] = dat_q[gi-1];
      end
    end
  endgenerate

  // Ready ripples from the output back; an empty stage is always ready, so bubbles collapse.
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = !vld_q[DEPTH-1] | out_ready_i;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = !vld_q[i] | rdy[i+1];
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i];
      if (flush_i) begin
        vld_d[i] = 1'b0;
        dat_d[i] = RST_VAL;
      end else if (rdy[i]) begin
        vld_d[i] = up_vld[i];
        if (up_vld[i]) begin
          dat_d[i] = up_dat[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= RST_VAL;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign in_ready_o  = rdy[0] & !flush_i;
  assign out_valid_o = vld_q[DEPTH-1];
  assign out_data_o  = dat_q[DEPTH-1];

`ifdef NF_REGISTER_PIPE_OCC_EN
  logic          accept;
  logic          deliver;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  assign accept  = in_valid_i & in_ready_o;
  assign deliver = out_valid_o & out_ready_i;

  // A delivery during flush is still counted, but flush clears the count anyway.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (accept && !deliver) begin
      occ_d = occ_q + OW'(1);
    end else if (!accept && deliver) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;
`else
  assign occ_o = '0;
`endif

endmodule

// File: tb/tb_nf_register_pipe.sv
// Self-checking bench for nf_register_pipe: cycle table on a DEPTH=2 pipe, async-reset sequence,
// and a randomized scoreboard run on a DEPTH=1 pipe.
module tb_nf_register_pipe;

`ifdef NF_REGISTER_PIPE_OCC_EN
  localparam bit OCC_ON = 1'b1;
`else
  localparam bit OCC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // DUT A: DEPTH=2, WIDTH=8, RST_VAL=0x5A
  logic       flush_a, iv_a, or_a;
  logic [7:0] id_a;
  logic       ir_a, ov_a;
  logic [7:0] od_a;
  logic [1:0] occ_a;
  // DUT B: DEPTH=1, WIDTH=8, RST_VAL=0
  logic       flush_b, iv_b, or_b;
  logic [7:0] id_b;
  logic       ir_b, ov_b;
  logic [7:0] od_b;
  logic [0:0] occ_b;

  nf_register_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h5A)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .in_data_i(id_a),
    .out_valid_o(ov_a), .out_ready_i(or_a), .out_data_o(od_a),
    .occ_o(occ_a)
  );

  nf_register_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .in_data_i(id_b),
    .out_valid_o(ov_b), .out_ready_i(or_b), .out_data_o(od_b),
    .occ_o(occ_b)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] occ_x(input logic [1:0] n);
    return n & {2{OCC_ON}};
  endfunction

  // Scoreboard for DUT A, called at the sampling point of each cycle.
  task automatic sb_step_a();
    logic [7:0] exp;
    if (ov_a && or_a) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_beat", {24'd0, od_a}, 32'hFFFF_FFFF);
      end else begin
        exp = sb_a.pop_front();
        check("a_delivered_data", {24'd0, od_a}, {24'd0, exp});
      end
    end
    if (iv_a && ir_a) sb_a.push_back(id_a);
    if (flush_a) sb_a.delete();
  endtask

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [7:0] exp_b;
    int         guard;

    // fl iv  d      or  ir  ov  od     occ
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h5A, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h5A, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 2'd2};
    tbl[3]  = '{1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h33, 2'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h33, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'hA0, 2'd2};
    tbl[9]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2};
    tbl[10] = '{1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b0, 8'h5A, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'h5A, 2'd1};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC1, 2'd2};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 2'd0};

    rst = 1'b1;
    flush_a = 1'b0; iv_a = 1'b0; or_a = 1'b0; id_a = 8'h00;
    flush_b = 1'b0; iv_b = 1'b0; or_b = 1'b0; id_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, ov_a}, 32'd0);
    check("reset_out_data", {24'd0, od_a}, 32'h5A);
    check("reset_occ", {30'd0, occ_a}, 32'd0);
    check("reset_in_ready", {31'd0, ir_a}, 32'd1);
    #2 rst = 1'b0;

    for (int r = 0; r < 14; r++) begin
      @(posedge clk);
      #1;
      flush_a = tbl[r].fl; iv_a = tbl[r].iv; id_a = tbl[r].d; or_a = tbl[r].ordy;
      @(negedge clk);
      $display("row %0d: fl=%0b iv=%0b d=%02h or=%0b -> ir=%0b ov=%0b od=%02h occ=%0d",
               r, flush_a, iv_a, id_a, or_a, ir_a, ov_a, od_a, occ_a);
      check($sformatf("row%0d_in_ready", r), {31'd0, ir_a}, {31'd0, tbl[r].e_ir});
      check($sformatf("row%0d_out_valid", r), {31'd0, ov_a}, {31'd0, tbl[r].e_ov});
      check($sformatf("row%0d_out_data", r), {24'd0, od_a}, {24'd0, tbl[r].e_od});
      check($sformatf("row%0d_occ", r), {30'd0, occ_a}, {30'd0, occ_x(tbl[r].e_occ)});
      sb_step_a();
    end

    // Asynchronous reset with two beats held.
    @(posedge clk); #1;
    iv_a = 1'b1; id_a = 8'hD1; or_a = 1'b0;
    @(negedge clk); sb_step_a();
    @(posedge clk); #1;
    id_a = 8'hD2;
    @(negedge clk); sb_step_a();
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(negedge clk);
    check("prerst_out_valid", {31'd0, ov_a}, 32'd1);
    check("prerst_out_data", {24'd0, od_a}, 32'hD1);
    check("prerst_occ", {30'd0, occ_a}, {30'd0, occ_x(2'd2)});
    sb_step_a();
    #2 rst = 1'b1;
    #1;
    $display("async reset asserted mid-cycle: ov=%0b od=%02h occ=%0d", ov_a, od_a, occ_a);
    check("arst_out_valid", {31'd0, ov_a}, 32'd0);
    check("arst_out_data", {24'd0, od_a}, 32'h5A);
    check("arst_occ", {30'd0, occ_a}, 32'd0);
    check("arst_in_ready", {31'd0, ir_a}, 32'd1);
    sb_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", {31'd0, ov_a}, 32'd0);

    // Randomized run on the single-stage pipe.
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      iv_b = ($urandom_range(0, 3) != 0);
      id_b = 8'($urandom_range(0, 255));
      or_b = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("b_in_ready", {31'd0, ir_b}, {31'd0, (!ov_b) | or_b});
      check("b_occ", {31'd0, occ_b}, {31'd0, ov_b & OCC_ON});
      if (ov_b && or_b) begin
        if (sb_b.size() == 0) begin
          check("b_unexpected_beat", {24'd0, od_b}, 32'hFFFF_FFFF);
        end else begin
          exp_b = sb_b.pop_front();
          check("b_delivered_data", {24'd0, od_b}, {24'd0, exp_b});
        end
      end
      if (iv_b && ir_b) sb_b.push_back(id_b);
    end

    // Drain with a bounded cycle budget.
    @(posedge clk); #1;
    iv_b = 1'b0; or_b = 1'b1;
    guard = 0;
    @(negedge clk);
    while (sb_b.size() != 0 && guard < 8) begin
      if (ov_b) begin
        exp_b = sb_b.pop_front();
        check("b_drain_data", {24'd0, od_b}, {24'd0, exp_b});
      end
      guard++;
      @(negedge clk);
    end
    check("b_drain_left", sb_b.size(), 32'd0);
    check("b_drain_out_valid", {31'd0, ov_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
